ysyx_22041412_axi_rw_master: RTL and testbench



---
 rtl/ysyx_22041412_axi_pkg.sv | 37 +++
 rtl/ysyx_22041412_axi_wr_align.sv | 27 ++
 rtl/ysyx_22041412_axi_rw_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_ysyx_22041412_axi_rw_master.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_axi_pkg.sv
// ysyx_22041412_axi_pkg
// Shared definitions for the AXI4 read/write master:
//   - read and write FSM state encodings
//   - AXI burst / response constants
//   - mask_to_size: arbiter byte mask -> AxSIZE
// No ports (package).

package ysyx_22041412_axi_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2,
      R_DONE = 2'd3
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_RESP = 2'd2,
      W_DONE = 2'd3
   } w_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Unknown masks fall back to a full doubleword transfer.
   function automatic logic [2:0] mask_to_size(input logic [7:0] mask);
      case (mask)
         8'h01:   return 3'd0;
         8'h03:   return 3'd1;
         8'h0F:   return 3'd2;
         default: return 3'd3;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22041412_axi_wr_align.sv
// ysyx_22041412_axi_wr_align
// Combinational write-lane shifter: moves byte-0-aligned write data and its
// byte mask into the lanes selected by the low address bits.
// Ports:
//   addr_off_i  in   3  byte offset within the 64-bit beat (addr[2:0])
//   mask_i      in   8  byte mask aligned at byte 0
//   data_i      in  64  write data aligned at byte 0
//   strb_o      out  8  shifted mask, bytes pushed past lane 7 are dropped
//   data_o      out 64  shifted data

module ysyx_22041412_axi_wr_align
   import ysyx_22041412_axi_pkg::*;
(
   input  logic [2:0]  addr_off_i,
   input  logic [7:0]  mask_i,
   input  logic [63:0] data_i,
   output logic [7:0]  strb_o,
   output logic [63:0] data_o
);

   logic [5:0] bit_off;

   assign bit_off = {addr_off_i, 3'b000};
   assign strb_o  = mask_i << addr_off_i;
   assign data_o  = data_i << bit_off;

endmodule

// File: rtl/ysyx_22041412_axi_rw_master.sv
// ysyx_22041412_axi_rw_master
// AXI4 master behind the IF/MEM arbiter. Independent read and write FSMs turn
// flat arbiter requests into AR/R and AW/W/B transactions.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   r_valid_i/addr/size/len  read request (size is a byte mask, len = beats-1)
//   r_ready_o, r_last_i      one-cycle pulse per delivered beat / final beat
//   data_read_o              raw read beat data
//   w_valid_i/addr/data/size write request (w_len_i ignored, single beat)
//   w_ready_o, w_last_i      one-cycle pulse on write completion
//   resp_err_o               pulse alongside a completion with non-OKAY response
//   axi_aw_*/w_*/b_*/ar_*/r_* the five AXI4 channels

module ysyx_22041412_axi_rw_master
   import ysyx_22041412_axi_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
)(
   input  logic                      clk,
   input  logic                      rst,

   input  logic                      r_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] r_addr_i,
   input  logic [7:0]                r_size_i,
   input  logic [7:0]                r_len_i,
   output logic                      r_ready_o,
   output logic [AXI_DATA_WIDTH-1:0] data_read_o,
   output logic                      r_last_i,

   input  logic                      w_valid_i,
   input  logic [AXI_ADDR_WIDTH-1:0] w_addr_i,
   input  logic [AXI_DATA_WIDTH-1:0] rw_w_data_i,
   input  logic [7:0]                w_size_i,
   input  logic [7:0]                w_len_i,
   output logic                      w_ready_o,
   output logic                      w_last_i,
   output logic                      resp_err_o,

   output logic                      axi_aw_valid_o,
   input  logic                      axi_aw_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_o,
   output logic [7:0]                axi_aw_len_o,
   output logic [2:0]                axi_aw_size_o,
   output logic [1:0]                axi_aw_burst_o,
   output logic [AXI_ID_WIDTH-1:0]   axi_aw_id_o,

   output logic                      axi_w_valid_o,
   input  logic                      axi_w_ready_i,
   output logic [AXI_DATA_WIDTH-1:0] axi_w_data_o,
   output logic [AXI_STRB_WIDTH-1:0] axi_w_strb_o,
   output logic                      axi_w_last_o,

   input  logic                      axi_b_valid_i,
   output logic                      axi_b_ready_o,
   input  logic [1:0]                axi_b_resp_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_b_id_i,

   output logic                      axi_ar_valid_o,
   input  logic                      axi_ar_ready_i,
   output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
   output logic [7:0]                axi_ar_len_o,
   output logic [2:0]                axi_ar_size_o,
   output logic [1:0]                axi_ar_burst_o,
   output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,

   input  logic                      axi_r_valid_i,
   output logic                      axi_r_ready_o,
   input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
   input  logic [1:0]                axi_r_resp_i,
   input  logic                      axi_r_last_i,
   input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i
);

   r_state_e                  r_state_q, r_state_d;
   logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
   logic [7:0]                ar_len_q, ar_len_d;
   logic [2:0]                ar_size_q, ar_size_d;
   logic [AXI_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                      rd_pulse_q, rd_pulse_d;
   logic                      rd_last_q, rd_last_d;
   logic                      r_err_hit;

   w_state_e                  w_state_q, w_state_d;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic [7:0]                w_mask_q, w_mask_d;
   logic [AXI_DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic                      aw_done_q, aw_done_d;
   logic                      w_done_q, w_done_d;
   logic                      wr_pulse_q, wr_pulse_d;
   logic                      w_err_hit;

   logic                      resp_err_q, resp_err_d;
   logic                      aw_hs, w_hs;
   logic                      unused_inputs;

   // Write length, and response IDs are never consulted: writes are always
   // single-beat and every request is issued with ID 0.
   assign unused_inputs = ^{w_len_i, axi_b_id_i, axi_r_id_i};

   assign axi_aw_valid_o = (w_state_q == W_REQ) && !aw_done_q;
   assign axi_w_valid_o  = (w_state_q == W_REQ) && !w_done_q;
   assign aw_hs          = axi_aw_valid_o && axi_aw_ready_i;
   assign w_hs           = axi_w_valid_o && axi_w_ready_i;

   // Read FSM next-state: latch request, issue AR, collect beats, then one
   // dead cycle so the arbiter can drop or switch its request.
   always_comb begin
      r_state_d  = r_state_q;
      ar_addr_d  = ar_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      rd_data_d  = rd_data_q;
      rd_pulse_d = 1'b0;
      rd_last_d  = 1'b0;
      r_err_hit  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (r_valid_i) begin
               ar_addr_d = r_addr_i;
               ar_len_d  = r_len_i;
               ar_size_d = mask_to_size(r_size_i);
               r_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            if (axi_ar_ready_i) r_state_d = R_DATA;
         end
         R_DATA: begin
            if (axi_r_valid_i) begin
               rd_data_d  = axi_r_data_i;
               rd_pulse_d = 1'b1;
               rd_last_d  = axi_r_last_i;
               r_err_hit  = (axi_r_resp_i != AXI_RESP_OKAY);
               if (axi_r_last_i) r_state_d = R_DONE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write FSM next-state: AW and W are offered together and each retires on
   // its own handshake; B is only accepted once both have gone.
   always_comb begin
      w_state_d  = w_state_q;
      aw_addr_d  = aw_addr_q;
      w_mask_d   = w_mask_q;
      w_data_d   = w_data_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      wr_pulse_d = 1'b0;
      w_err_hit  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (w_valid_i) begin
               aw_addr_d = w_addr_i;
               w_mask_d  = w_size_i;
               w_data_d  = rw_w_data_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               w_state_d = W_REQ;
            end
         end
         W_REQ: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (axi_b_valid_i) begin
               wr_pulse_d = 1'b1;
               w_err_hit  = (axi_b_resp_i != AXI_RESP_OKAY);
               w_state_d  = W_DONE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign resp_err_d = r_err_hit || w_err_hit;

   // State and output registers for both paths; reset abandons any
   // in-flight transaction.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state_q  <= R_IDLE;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         rd_data_q  <= '0;
         rd_pulse_q <= 1'b0;
         rd_last_q  <= 1'b0;
         w_state_q  <= W_IDLE;
         aw_addr_q  <= '0;
         w_mask_q   <= '0;
         w_data_q   <= '0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         wr_pulse_q <= 1'b0;
         resp_err_q <= 1'b0;
      end else begin
         r_state_q  <= r_state_d;
         ar_addr_q  <= ar_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         rd_data_q  <= rd_data_d;
         rd_pulse_q <= rd_pulse_d;
         rd_last_q  <= rd_last_d;
         w_state_q  <= w_state_d;
         aw_addr_q  <= aw_addr_d;
         w_mask_q   <= w_mask_d;
         w_data_q   <= w_data_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         wr_pulse_q <= wr_pulse_d;
         resp_err_q <= resp_err_d;
      end
   end

   ysyx_22041412_axi_wr_align u_wr_align (
      .addr_off_i (aw_addr_q[2:0]),
      .mask_i     (w_mask_q),
      .data_i     (w_data_q),
      .strb_o     (axi_w_strb_o),
      .data_o     (axi_w_data_o)
   );

   assign axi_ar_valid_o = (r_state_q == R_ADDR);
   assign axi_ar_addr_o  = ar_addr_q;
   assign axi_ar_len_o   = ar_len_q;
   assign axi_ar_size_o  = ar_size_q;
   assign axi_ar_burst_o = AXI_BURST_INCR;
   assign axi_ar_id_o    = '0;
   assign axi_r_ready_o  = (r_state_q == R_DATA);

   assign axi_aw_addr_o  = aw_addr_q;
   assign axi_aw_len_o   = 8'd0;
   assign axi_aw_size_o  = mask_to_size(w_mask_q);
   assign axi_aw_burst_o = AXI_BURST_INCR;
   assign axi_aw_id_o    = '0;
   assign axi_w_last_o   = 1'b1;
   assign axi_b_ready_o  = (w_state_q == W_RESP);

   assign r_ready_o   = rd_pulse_q;
   assign r_last_i    = rd_last_q;
   assign data_read_o = rd_data_q;
   assign w_ready_o   = wr_pulse_q;
   assign w_last_i    = wr_pulse_q;
   assign resp_err_o  = resp_err_q;

endmodule

// File: tb/tb_ysyx_22041412_axi_rw_master.sv
// tb_ysyx_22041412_axi_rw_master
// Self-checking bench: acts as the AXI slave and the arbiter, compares channel
// fields and returned beats/completions against a byte-level model.

module tb_ysyx_22041412_axi_rw_master;

   logic        clk;
   logic        rst;
   logic        r_valid_i;
   logic [31:0] r_addr_i;
   logic [7:0]  r_size_i;
   logic [7:0]  r_len_i;
   logic        r_ready_o;
   logic [63:0] data_read_o;
   logic        r_last_i;
   logic        w_valid_i;
   logic [31:0] w_addr_i;
   logic [63:0] rw_w_data_i;
   logic [7:0]  w_size_i;
   logic [7:0]  w_len_i;
   logic        w_ready_o;
   logic        w_last_i;
   logic        resp_err_o;
   logic        axi_aw_valid_o, axi_aw_ready_i;
   logic [31:0] axi_aw_addr_o;
   logic [7:0]  axi_aw_len_o;
   logic [2:0]  axi_aw_size_o;
   logic [1:0]  axi_aw_burst_o;
   logic [3:0]  axi_aw_id_o;
   logic        axi_w_valid_o, axi_w_ready_i;
   logic [63:0] axi_w_data_o;
   logic [7:0]  axi_w_strb_o;
   logic        axi_w_last_o;
   logic        axi_b_valid_i, axi_b_ready_o;
   logic [1:0]  axi_b_resp_i;
   logic [3:0]  axi_b_id_i;
   logic        axi_ar_valid_o, axi_ar_ready_i;
   logic [31:0] axi_ar_addr_o;
   logic [7:0]  axi_ar_len_o;
   logic [2:0]  axi_ar_size_o;
   logic [1:0]  axi_ar_burst_o;
   logic [3:0]  axi_ar_id_o;
   logic        axi_r_valid_i, axi_r_ready_o;
   logic [63:0] axi_r_data_i;
   logic [1:0]  axi_r_resp_i;
   logic        axi_r_last_i;
   logic [3:0]  axi_r_id_i;

   int errors = 0;
   int checks = 0;
   int strayErr = 0;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic        err;
   } rdBeat_t;

   typedef struct {
      logic last;
      logic err;
   } wrDone_t;

   rdBeat_t rdQ[$];
   wrDone_t wrQ[$];

   typedef struct {
      bit          isWrite;
      logic [31:0] addr;
      logic [7:0]  mask;
      logic [7:0]  len;
      logic [63:0] data;
      int          delayA;
      int          delayB;
      int          delayC;
      logic [1:0]  resp;
      int          errBeat;
      logic [2:0]  expSize;
      logic [7:0]  expStrb;
      logic [63:0] expWdata;
   } vec_t;

   vec_t vecs[$];

   ysyx_22041412_axi_rw_master dut (
      .clk(clk), .rst(rst),
      .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_size_i(r_size_i), .r_len_i(r_len_i),
      .r_ready_o(r_ready_o), .data_read_o(data_read_o), .r_last_i(r_last_i),
      .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .rw_w_data_i(rw_w_data_i),
      .w_size_i(w_size_i), .w_len_i(w_len_i),
      .w_ready_o(w_ready_o), .w_last_i(w_last_i), .resp_err_o(resp_err_o),
      .axi_aw_valid_o(axi_aw_valid_o), .axi_aw_ready_i(axi_aw_ready_i),
      .axi_aw_addr_o(axi_aw_addr_o), .axi_aw_len_o(axi_aw_len_o),
      .axi_aw_size_o(axi_aw_size_o), .axi_aw_burst_o(axi_aw_burst_o), .axi_aw_id_o(axi_aw_id_o),
      .axi_w_valid_o(axi_w_valid_o), .axi_w_ready_i(axi_w_ready_i),
      .axi_w_data_o(axi_w_data_o), .axi_w_strb_o(axi_w_strb_o), .axi_w_last_o(axi_w_last_o),
      .axi_b_valid_i(axi_b_valid_i), .axi_b_ready_o(axi_b_ready_o),
      .axi_b_resp_i(axi_b_resp_i), .axi_b_id_i(axi_b_id_i),
      .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready_i),
      .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_len_o(axi_ar_len_o),
      .axi_ar_size_o(axi_ar_size_o), .axi_ar_burst_o(axi_ar_burst_o), .axi_ar_id_o(axi_ar_id_o),
      .axi_r_valid_i(axi_r_valid_i), .axi_r_ready_o(axi_r_ready_o),
      .axi_r_data_i(axi_r_data_i), .axi_r_resp_i(axi_r_resp_i),
      .axi_r_last_i(axi_r_last_i), .axi_r_id_i(axi_r_id_i)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a sequence ever stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Completion monitor: records every arbiter-side pulse on the falling edge
   // and flags error/last pulses that appear without a matching completion.
   always @(negedge clk) begin
      if (r_ready_o) rdQ.push_back('{data: data_read_o, last: r_last_i, err: resp_err_o});
      if (w_ready_o) wrQ.push_back('{last: w_last_i, err: resp_err_o});
      if (resp_err_o && !r_ready_o && !w_ready_o) strayErr++;
      if (r_last_i && !r_ready_o) strayErr++;
      if (w_last_i && !w_ready_o) strayErr++;
   end

   // Reference model: AxSIZE is log2 of the byte count for the four legal
   // masks, full doubleword otherwise.
   function automatic logic [2:0] modelSize(input logic [7:0] mask);
      int n;
      n = $countones(mask);
      if ((mask == 8'h01) || (mask == 8'h03) || (mask == 8'h0F) || (mask == 8'hFF))
         return 3'($clog2(n));
      return 3'd3;
   endfunction

   // Reference model: byte i of the beat carries source byte (i - offset).
   function automatic logic [7:0] modelStrb(input logic [31:0] addr, input logic [7:0] mask);
      logic [7:0] s;
      int off;
      s = '0;
      off = int'(addr % 8);
      for (int i = 0; i < 8; i++)
         if (i >= off) s[i] = mask[i - off];
      return s;
   endfunction

   function automatic logic [63:0] modelWdata(input logic [31:0] addr, input logic [63:0] d);
      logic [63:0] r;
      int off;
      r = '0;
      off = int'(addr % 8);
      for (int i = 0; i < 8; i++)
         if (i >= off) r[i*8 +: 8] = d[(i-off)*8 +: 8];
      return r;
   endfunction

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // After reset every handshake signal and arbiter pulse must be quiet.
   task automatic checkIdle(input string tag);
      checkOutput({tag, " arvalid"}, axi_ar_valid_o, 0);
      checkOutput({tag, " rready"}, axi_r_ready_o, 0);
      checkOutput({tag, " awvalid"}, axi_aw_valid_o, 0);
      checkOutput({tag, " wvalid"}, axi_w_valid_o, 0);
      checkOutput({tag, " bready"}, axi_b_ready_o, 0);
      checkOutput({tag, " r_ready_o"}, r_ready_o, 0);
      checkOutput({tag, " r_last_i"}, r_last_i, 0);
      checkOutput({tag, " w_ready_o"}, w_ready_o, 0);
      checkOutput({tag, " w_last_i"}, w_last_i, 0);
      checkOutput({tag, " resp_err_o"}, resp_err_o, 0);
      checkOutput({tag, " data_read_o"}, data_read_o, 0);
   endtask

   // Full read transaction as arbiter plus slave. beat0 overrides the first
   // returned beat when non-zero; other beats are random.
   task automatic readTxn(input logic [31:0] addr, input logic [7:0] mask, input logic [7:0] len,
                          input int arDelay, input int rGap, input int errBeat,
                          input logic [63:0] beat0, input logic [2:0] expSize);
      logic [63:0] sent[$];
      logic [63:0] d;
      rdQ.delete();
      @(negedge clk);
      r_valid_i = 1'b1; r_addr_i = addr; r_size_i = mask; r_len_i = len;
      @(negedge clk);
      r_valid_i = 1'b0; r_addr_i = $urandom; r_size_i = 8'($urandom); r_len_i = 8'($urandom);
      for (int c = 0; c <= arDelay; c++) begin
         checkOutput("arvalid", axi_ar_valid_o, 1);
         checkOutput("araddr", axi_ar_addr_o, addr);
         checkOutput("arlen", axi_ar_len_o, len);
         checkOutput("arsize", axi_ar_size_o, expSize);
         checkOutput("arburst", axi_ar_burst_o, 2'b01);
         checkOutput("rready early", axi_r_ready_o, 0);
         axi_ar_ready_i = (c == arDelay);
         @(negedge clk);
      end
      axi_ar_ready_i = 1'b0;
      checkOutput("arvalid drop", axi_ar_valid_o, 0);
      for (int b = 0; b <= int'(len); b++) begin
         for (int g = 0; g < rGap; g++) begin
            axi_r_valid_i = 1'b0;
            @(negedge clk);
         end
         d = (b == 0 && beat0 != 0) ? beat0 : {$urandom, $urandom};
         sent.push_back(d);
         axi_r_valid_i = 1'b1; axi_r_data_i = d;
         axi_r_last_i = (b == int'(len));
         axi_r_resp_i = (b == errBeat) ? 2'b10 : 2'b00;
         checkOutput("rready", axi_r_ready_o, 1);
         @(negedge clk);
      end
      axi_r_valid_i = 1'b0; axi_r_last_i = 1'b0; axi_r_resp_i = 2'b00;
      repeat (3) @(negedge clk);
      checkOutput("rd beat count", rdQ.size(), int'(len) + 1);
      for (int b = 0; b < rdQ.size() && b < sent.size(); b++) begin
         checkOutput("rd data", rdQ[b].data, sent[b]);
         checkOutput("rd last", rdQ[b].last, b == int'(len));
         checkOutput("rd err", rdQ[b].err, b == errBeat);
      end
   endtask

   // Full write transaction; AW and W are accepted after independent delays.
   task automatic writeTxn(input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data,
                           input int awDelay, input int wDelay, input int bDelay, input logic [1:0] bresp,
                           input logic [2:0] expSize, input logic [7:0] expStrb, input logic [63:0] expWdata);
      int lastC;
      lastC = (awDelay > wDelay) ? awDelay : wDelay;
      wrQ.delete();
      @(negedge clk);
      w_valid_i = 1'b1; w_addr_i = addr; w_size_i = mask; rw_w_data_i = data;
      w_len_i = 8'($urandom_range(1, 255));
      @(negedge clk);
      w_valid_i = 1'b0; w_addr_i = $urandom; w_size_i = 8'($urandom); rw_w_data_i = {$urandom, $urandom};
      for (int c = 0; c <= lastC; c++) begin
         checkOutput("awvalid", axi_aw_valid_o, c <= awDelay);
         if (c <= awDelay) begin
            checkOutput("awaddr", axi_aw_addr_o, addr);
            checkOutput("awlen", axi_aw_len_o, 0);
            checkOutput("awsize", axi_aw_size_o, expSize);
            checkOutput("awburst", axi_aw_burst_o, 2'b01);
         end
         checkOutput("wvalid", axi_w_valid_o, c <= wDelay);
         if (c <= wDelay) begin
            checkOutput("wstrb", axi_w_strb_o, expStrb);
            checkOutput("wdata", axi_w_data_o, expWdata);
            checkOutput("wlast", axi_w_last_o, 1);
         end
         checkOutput("bready early", axi_b_ready_o, 0);
         axi_aw_ready_i = (c == awDelay);
         axi_w_ready_i = (c == wDelay);
         @(negedge clk);
      end
      axi_aw_ready_i = 1'b0; axi_w_ready_i = 1'b0;
      checkOutput("awvalid drop", axi_aw_valid_o, 0);
      checkOutput("wvalid drop", axi_w_valid_o, 0);
      repeat (bDelay) begin
         checkOutput("bready", axi_b_ready_o, 1);
         @(negedge clk);
      end
      axi_b_valid_i = 1'b1; axi_b_resp_i = bresp;
      checkOutput("bready", axi_b_ready_o, 1);
      @(negedge clk);
      axi_b_valid_i = 1'b0; axi_b_resp_i = 2'b00;
      repeat (3) @(negedge clk);
      checkOutput("wr done count", wrQ.size(), 1);
      if (wrQ.size() > 0) begin
         checkOutput("wr last", wrQ[0].last, 1);
         checkOutput("wr err", wrQ[0].err, bresp != 2'b00);
      end
   endtask

   // Dispatch one table record to the read or write sequence.
   task automatic applyStimulus(input vec_t v);
      if (v.isWrite)
         writeTxn(v.addr, v.mask, v.data, v.delayA, v.delayB, v.delayC, v.resp,
                  v.expSize, v.expStrb, v.expWdata);
      else
         readTxn(v.addr, v.mask, v.len, v.delayA, v.delayB, v.errBeat, v.data, v.expSize);
   endtask

   // Main sequence: reset, directed table, concurrent traffic, mid-burst
   // reset, then randomized transactions against the model.
   initial begin
      rst = 1'b0;
      r_valid_i = 0; r_addr_i = 0; r_size_i = 0; r_len_i = 0;
      w_valid_i = 0; w_addr_i = 0; rw_w_data_i = 0; w_size_i = 0; w_len_i = 0;
      axi_aw_ready_i = 0; axi_w_ready_i = 0; axi_b_valid_i = 0; axi_b_resp_i = 0; axi_b_id_i = 0;
      axi_ar_ready_i = 0; axi_r_valid_i = 0; axi_r_data_i = 0; axi_r_resp_i = 0;
      axi_r_last_i = 0; axi_r_id_i = 0;
      repeat (3) @(negedge clk);
      checkIdle("reset");
      rst = 1'b1;
      @(negedge clk);
      checkIdle("post-reset");
      checkOutput("arid", axi_ar_id_o, 0);
      checkOutput("awid", axi_aw_id_o, 0);

      vecs.push_back('{isWrite: 0, addr: 32'h8000_0004, mask: 8'h0F, len: 8'd0, data: 64'h1122334455667788,
                       delayA: 0, delayB: 0, delayC: 0, resp: 2'b00, errBeat: -1,
                       expSize: 3'd2, expStrb: 8'h00, expWdata: 64'h0});
      vecs.push_back('{isWrite: 0, addr: 32'h8000_1000, mask: 8'hFF, len: 8'd3, data: 64'h0,
                       delayA: 3, delayB: 1, delayC: 0, resp: 2'b00, errBeat: -1,
                       expSize: 3'd3, expStrb: 8'h00, expWdata: 64'h0});
      vecs.push_back('{isWrite: 1, addr: 32'h8000_0003, mask: 8'h03, len: 8'd0, data: 64'hABCD,
                       delayA: 0, delayB: 2, delayC: 1, resp: 2'b00, errBeat: -1,
                       expSize: 3'd1, expStrb: 8'h18, expWdata: 64'h0000_00AB_CD00_0000});
      vecs.push_back('{isWrite: 1, addr: 32'h8000_0010, mask: 8'hFF, len: 8'd0, data: 64'h0123_4567_89AB_CDEF,
                       delayA: 1, delayB: 0, delayC: 0, resp: 2'b10, errBeat: -1,
                       expSize: 3'd3, expStrb: 8'hFF, expWdata: 64'h0123_4567_89AB_CDEF});
      vecs.push_back('{isWrite: 1, addr: 32'h8000_0006, mask: 8'h0F, len: 8'd0, data: 64'hDEAD_BEEF,
                       delayA: 0, delayB: 0, delayC: 0, resp: 2'b00, errBeat: -1,
                       expSize: 3'd2, expStrb: 8'hC0, expWdata: 64'hBEEF_0000_0000_0000});
      vecs.push_back('{isWrite: 0, addr: 32'h8000_0007, mask: 8'h01, len: 8'd1, data: 64'h0,
                       delayA: 1, delayB: 0, delayC: 0, resp: 2'b00, errBeat: 1,
                       expSize: 3'd0, expStrb: 8'h00, expWdata: 64'h0});
      vecs.push_back('{isWrite: 0, addr: 32'h8000_0002, mask: 8'h03, len: 8'd0, data: 64'h0,
                       delayA: 0, delayB: 2, delayC: 0, resp: 2'b00, errBeat: -1,
                       expSize: 3'd1, expStrb: 8'h00, expWdata: 64'h0});
      vecs.push_back('{isWrite: 1, addr: 32'h8000_0007, mask: 8'h01, len: 8'd0, data: 64'h5A,
                       delayA: 2, delayB: 1, delayC: 2, resp: 2'b00, errBeat: -1,
                       expSize: 3'd0, expStrb: 8'h80, expWdata: 64'h5A00_0000_0000_0000});
      vecs.push_back('{isWrite: 1, addr: 32'h8000_0000, mask: 8'h77, len: 8'd0, data: 64'h1111,
                       delayA: 0, delayB: 0, delayC: 0, resp: 2'b11, errBeat: -1,
                       expSize: 3'd3, expStrb: 8'h77, expWdata: 64'h1111});
      foreach (vecs[i]) applyStimulus(vecs[i]);

      $display("[TB] concurrent read and write");
      fork
         readTxn(32'h8000_2000, 8'hFF, 8'd1, 0, 0, -1, 64'h0, 3'd3);
         writeTxn(32'h8000_3005, 8'h03, 64'h00BE, 1, 0, 0, 2'b00, 3'd1, 8'h60, 64'h0000_BE00_0000_0000);
      join

      $display("[TB] reset during read burst");
      @(negedge clk);
      r_valid_i = 1'b1; r_addr_i = 32'h8000_4000; r_size_i = 8'hFF; r_len_i = 8'd3;
      @(negedge clk);
      r_valid_i = 1'b0;
      checkOutput("rst-seq arvalid", axi_ar_valid_o, 1);
      axi_ar_ready_i = 1'b1;
      @(negedge clk);
      axi_ar_ready_i = 1'b0;
      checkOutput("rst-seq rready", axi_r_ready_o, 1);
      axi_r_valid_i = 1'b1; axi_r_data_i = 64'hCAFE_F00D_0000_0001; axi_r_last_i = 1'b0;
      @(negedge clk);
      axi_r_valid_i = 1'b0;
      checkOutput("rst-seq beat1", r_ready_o, 1);
      rst = 1'b0;
      @(negedge clk);
      checkIdle("mid-reset");
      rst = 1'b1;
      readTxn(32'h8000_5008, 8'h0F, 8'd0, 0, 0, -1, 64'h0, 3'd2);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 24; n++) begin
         logic [31:0] a;
         logic [7:0]  m;
         logic [63:0] d;
         int          pick;
         a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
         pick = $urandom_range(0, 4);
         case (pick)
            0: m = 8'h01;
            1: m = 8'h03;
            2: m = 8'h0F;
            3: m = 8'hFF;
            default: m = 8'($urandom);
         endcase
         if ($urandom_range(0, 1) == 1) begin
            d = {$urandom, $urandom};
            writeTxn(a, m, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                     ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00,
                     modelSize(m), modelStrb(a, m), modelWdata(a, d));
         end else begin
            logic [7:0] l;
            l = 8'($urandom_range(0, 3));
            readTxn(a, m, l, $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(l))) : -1,
                    64'h0, modelSize(m));
         end
      end

      checkOutput("stray pulses", strayErr, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
